// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: instruction memory read port, decode-side control
// inputs and the IF/ID stage outputs, grouped for the fetch unit.
interface instr_fetch_unit_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16
);
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic               stall;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic [INSTR_W-1:0] instr_out;
    logic [ADDR_W-1:0]  pc_out;
    logic               instr_valid;
    logic               fetch_fault;
    logic [15:0]        fetch_count;

    // Fetch unit side
    modport master (
        output imem_addr,
        input  imem_data,
        input  stall,
        input  redirect_valid,
        input  redirect_pc,
        output instr_out,
        output pc_out,
        output instr_valid,
        output fetch_fault,
        output fetch_count
    );

    // Memory / decoder side
    modport slave (
        input  imem_addr,
        output imem_data,
        output stall,
        output redirect_valid,
        output redirect_pc,
        input  instr_out,
        input  pc_out,
        input  instr_valid,
        input  fetch_fault,
        input  fetch_count
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads 16-bit big-endian words
// from instruction memory, handles redirects/stalls and presents a
// registered IF/ID stage. A misaligned or out-of-range fetch locks the
// unit in FAULT until reset.
module instr_fetch_unit #(
    parameter int              ADDR_W    = 16,
    parameter int              INSTR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              MEM_BYTES = 256
) (
    input  logic               clk,
    input  logic               reset,
    instr_fetch_unit_if.master bus
);
    // One extra bit so PC+1 never wraps when compared to the memory size.
    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  r_pc_out;
    logic               r_valid;
    logic               r_fault;
    logic [15:0]        r_count;

    state_t             w_state;
    logic [ADDR_W-1:0]  w_pc;
    logic [INSTR_W-1:0] w_instr;
    logic [ADDR_W-1:0]  w_pc_out;
    logic               w_valid;
    logic               w_fault;
    logic [15:0]        w_count;

    logic               w_redir_bad;
    logic               w_pc_bad;

    // A word fetch touches addr and addr+1; both must lie inside memory.
    assign w_redir_bad = bus.redirect_pc[0] |
                         (({1'b0, bus.redirect_pc} + (ADDR_W+1)'(1)) >= MEM_LIMIT);
    assign w_pc_bad    = (({1'b0, r_pc} + (ADDR_W+1)'(1)) >= MEM_LIMIT);

    // Next-state and next-register values: redirect beats stall, stall holds all.
    always_comb begin
        w_state  = r_state;
        w_pc     = r_pc;
        w_instr  = r_instr;
        w_pc_out = r_pc_out;
        w_valid  = r_valid;
        w_fault  = r_fault;
        w_count  = r_count;
        case (r_state)
            ST_RUN: begin
                if (bus.redirect_valid) begin
                    w_valid = 1'b0;
                    if (w_redir_bad) begin
                        w_state = ST_FAULT;
                        w_fault = 1'b1;
                    end else begin
                        w_pc = bus.redirect_pc;
                    end
                end else if (bus.stall) begin
                    w_state = r_state;
                end else if (w_pc_bad) begin
                    w_state = ST_FAULT;
                    w_fault = 1'b1;
                    w_valid = 1'b0;
                end else begin
                    w_instr  = bus.imem_data;
                    w_pc_out = r_pc;
                    w_valid  = 1'b1;
                    w_pc     = r_pc + ADDR_W'(2);
                    if (r_count != 16'hFFFF) begin
                        w_count = r_count + 16'd1;
                    end
                end
            end
            ST_FAULT: begin
                w_valid = 1'b0;
            end
            default: begin
                w_state = ST_FAULT;
                w_fault = 1'b1;
                w_valid = 1'b0;
            end
        endcase
    end

    // State and IF/ID registers; synchronous reset restores power-on values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_RUN;
            r_pc     <= RESET_PC;
            r_instr  <= '0;
            r_pc_out <= '0;
            r_valid  <= 1'b0;
            r_fault  <= 1'b0;
            r_count  <= '0;
        end else begin
            r_state  <= w_state;
            r_pc     <= w_pc;
            r_instr  <= w_instr;
            r_pc_out <= w_pc_out;
            r_valid  <= w_valid;
            r_fault  <= w_fault;
            r_count  <= w_count;
        end
    end

    assign bus.imem_addr   = r_pc;
    assign bus.instr_out   = r_instr;
    assign bus.pc_out      = r_pc_out;
    assign bus.instr_valid = r_valid;
    assign bus.fetch_fault = r_fault;
    assign bus.fetch_count = r_count;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end initiator that drives the instruction memory read port and consumes its 16-bit big-endian instruction word.
- Holds the program counter, advances it by 2 bytes per fetch, and accepts branch/jump redirects and decode-stage stalls.
- Produces a registered IF/ID stage (instruction, its PC, valid) for the decoder.
- Flags a sticky fault on a misaligned or out-of-range fetch.

Parameters:
- ADDR_W, 16, width of PC and memory address.
- INSTR_W, 16, instruction width (two bytes, MSB byte at the lower address).
- RESET_PC, 16'h0000, PC value loaded on reset.
- MEM_BYTES, 256, size of the instruction memory in bytes; a fetch is legal only if PC+1 < MEM_BYTES.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  ADDR_W  address to instruction memory. Driven combinationally from the PC register.
- imem_data  in  INSTR_W  instruction word returned combinationally in the same cycle.
- stall  in  1  decode not ready. Hold PC and all IF/ID outputs.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  ADDR_W  redirect target byte address.
- instr_out  out  INSTR_W  registered instruction.
- pc_out  out  ADDR_W  registered PC of instr_out.
- instr_valid  out  1  instr_out/pc_out hold a real instruction.
- fetch_fault  out  1  sticky fault flag.
- fetch_count  out  16  number of valid instructions delivered, saturating at 16'hFFFF.

Behaviour:
- Reset is synchronous, active-high, on a clk edge with reset=1. It sets:
  - pc=RESET_PC, state=RUN, instr_out=0, pc_out=0.
  - instr_valid=0, fetch_fault=0, fetch_count=0.
- imem_addr equals pc at all times, including during reset.
- States are RUN and FAULT.
- RUN, evaluated in priority order at each edge:
  1. redirect_valid=1 (wins over stall):
     - Odd redirect_pc or redirect_pc+1 >= MEM_BYTES: go to FAULT, fetch_fault<=1, instr_valid<=0, pc unchanged.
     - Otherwise: pc<=redirect_pc, instr_valid<=0 (one-cycle bubble), instr_out/pc_out unchanged.
  2. stall=1: all registers hold.
  3. pc+1 >= MEM_BYTES: go to FAULT, fetch_fault<=1, instr_valid<=0.
  4. Otherwise, normal fetch:
     - instr_out<=imem_data, pc_out<=pc, instr_valid<=1.
     - pc<=pc+2, computed modulo 2^ADDR_W.
     - fetch_count<=fetch_count+1 unless it is already 16'hFFFF.
- FAULT:
  - imem_addr stays at the last PC; instr_valid=0.
  - redirect_valid and stall are ignored.
  - Exit only via reset.
- Latency: the instruction at address A appears on instr_out one edge after pc==A with no stall and no redirect.
- Throughput: one instruction per cycle.
- Stall semantics: while stall=1 the outputs are frozen. A valid instruction remains presented until stall drops, and is consumed on the edge where stall=0.
- Reset mid-operation (stalled, redirecting, or in FAULT) always wins and restores the reset state on that edge.
- The last legal fetch address is MEM_BYTES-2 (254). The next sequential fetch, from 256, faults.

Test Plan:
- Sequential fetch. Memory bytes 0..3 = E0,00,72,59, rest 00. Release reset.
  - Edge 1: instr_out=16'hE000, pc_out=0, valid=1.
  - Edge 2: instr_out=16'h7259, pc_out=2.
  - Edge 3: instr_out=16'h0000, pc_out=4.
  - fetch_count=3.
- Stall. Assert stall for 3 cycles after edge 1.
  - instr_out stays 16'hE000, pc_out=0, imem_addr=2, fetch_count=1 throughout.
  - Edge after release: instr_out=16'h7259.
- Redirect. Redirect to 16'h0002 while stall=1 at pc=4.
  - Next edge: instr_valid=0, imem_addr=2.
  - Following edge: instr_out=16'h7259, pc_out=2.
- Misaligned redirect. Redirect to 16'h0003.
  - fetch_fault=1, instr_valid=0.
  - Further redirects to 0 are ignored.
  - Reset clears fetch_fault and restores pc=0.
- End of memory. Redirect to 254 with bytes 254,255 = 12,34.
  - Next edge: bubble.
  - Then instr_out=16'h1234, pc_out=254.
  - Next edge: pc=256 fault, fetch_fault=1.
- Reset mid-stall. Assert reset with stall=1 and valid=1.
  - Next edge: instr_valid=0, pc=0, fetch_count=0.
